// File: rtl/pacman_pkg.sv
// Shared types for the sprite movement logic: heading encoding, movement FSM states
// and helpers that map open_dirs bit positions onto headings.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } move_state_t;

    localparam dir_t DIR_RESET = LEFT;

    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    // open_dirs and button vectors share the heading encoding, bit i == dir_t'(i)
    function automatic dir_t idx_to_dir(input logic [1:0] idx);
        return dir_t'(idx);
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// W-bit rising-edge detector; rise is combinational from the live level so a press
// is usable in the same cycle it arrives. Previous-level register clears on reset.
module rise_edge_det #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/dir_request_ctrl.sv
// Buffers direction presses and applies them on move_tick when the maze allows it.
// Optional macro DIR_INSTANT_REVERSE_EN: opposite-direction presses while moving flip dir at once.
module dir_request_ctrl
    import pacman_pkg::*;
#(
    parameter int HOLD_TICKS = 8,
    parameter int AGE_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_tick,
    input  logic [3:0] open_dirs,
    output logic [1:0] dir,
    output logic       moving,
    output logic       step,
    output logic       turn_evt
);

    logic [3:0]       press;
    logic             any_press;
    logic [1:0]       press_idx;
    dir_t             press_dir;

    move_state_t      state_q, state_n;
    dir_t             dir_q, dir_n;
    logic             step_q, step_n;
    logic             turn_q, turn_n;
    logic             req_valid_q, req_valid_n;
    dir_t             req_dir_q, req_dir_n;
    logic [AGE_W-1:0] age_q, age_n;

    dir_t             cur_dir;
    logic             new_press;
    logic             eff_valid;
    dir_t             eff_dir;
    logic [AGE_W-1:0] age_inc;

    rise_edge_det #(.W(4)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .level ({btn_right, btn_left, btn_down, btn_up}),
        .rise  (press)
    );

    // Lowest bit wins: UP > DOWN > LEFT > RIGHT
    always_comb begin
        any_press = |press;
        press_idx = 2'd0;
        if (press[0]) begin
            press_idx = 2'd0;
        end else if (press[1]) begin
            press_idx = 2'd1;
        end else if (press[2]) begin
            press_idx = 2'd2;
        end else if (press[3]) begin
            press_idx = 2'd3;
        end
        press_dir = idx_to_dir(press_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_RESET;
            step_q      <= 1'b0;
            turn_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_dir_q   <= DIR_RESET;
            age_q       <= '0;
        end else begin
            state_q     <= state_n;
            dir_q       <= dir_n;
            step_q      <= step_n;
            turn_q      <= turn_n;
            req_valid_q <= req_valid_n;
            req_dir_q   <= req_dir_n;
            age_q       <= age_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        dir_n       = dir_q;
        step_n      = 1'b0;
        turn_n      = 1'b0;
        req_valid_n = req_valid_q;
        req_dir_n   = req_dir_q;
        age_n       = age_q;
        cur_dir     = dir_q;
        new_press   = any_press;

`ifdef DIR_INSTANT_REVERSE_EN
        // A reversal consumes the press; a same-cycle tick then sees the new heading
        if (state_q == MOVING && any_press && press_dir == opposite_dir(dir_q)) begin
            cur_dir     = press_dir;
            dir_n       = press_dir;
            turn_n      = 1'b1;
            new_press   = 1'b0;
            req_valid_n = 1'b0;
            age_n       = '0;
        end
`endif

        eff_valid = new_press | req_valid_n;
        eff_dir   = new_press ? press_dir : req_dir_q;
        age_inc   = new_press ? AGE_W'(1) : age_q + AGE_W'(1);

        if (move_tick) begin
            if (eff_valid && open_dirs[eff_dir]) begin
                dir_n       = eff_dir;
                state_n     = MOVING;
                step_n      = 1'b1;
                turn_n      = turn_n | (eff_dir != cur_dir);
                req_valid_n = 1'b0;
                age_n       = '0;
            end else begin
                if (state_q == MOVING) begin
                    if (open_dirs[cur_dir]) begin
                        step_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                if (eff_valid) begin
                    req_dir_n = eff_dir;
                    if (age_inc >= AGE_W'(HOLD_TICKS)) begin
                        req_valid_n = 1'b0;
                        age_n       = '0;
                    end else begin
                        req_valid_n = 1'b1;
                        age_n       = age_inc;
                    end
                end
            end
        end else if (new_press) begin
            req_valid_n = 1'b1;
            req_dir_n   = press_dir;
            age_n       = '0;
        end
    end

    assign dir      = dir_q;
    assign moving   = (state_q == MOVING);
    assign step     = step_q;
    assign turn_evt = turn_q;

endmodule

// File: tb/tb_dir_request_ctrl.sv
// Self-checking bench for dir_request_ctrl: directed scenarios followed by random
// buttons, ticks and maze openings, all compared against a behavioural model.
module tb_dir_request_ctrl;

    localparam int HOLD = 2;

    logic       clk;
    logic       rst;
    logic [3:0] btns;
    logic       move_tick;
    logic [3:0] open_dirs;
    logic [1:0] dir;
    logic       moving;
    logic       step;
    logic       turn_evt;

    int total;
    int bad;

    // Behavioural model: heading as 0..3 (UP, DOWN, LEFT, RIGHT), request lifetime as a countdown
    int       m_dir;
    bit       m_moving;
    bit       m_reqv;
    int       m_reqd;
    int       m_left;
    bit [3:0] m_prev;
    bit       e_step;
    bit       e_turn;
    int       opp_tab[4] = '{1, 0, 3, 2};

    dir_request_ctrl #(
        .HOLD_TICKS (HOLD),
        .AGE_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btns[0]),
        .btn_down  (btns[1]),
        .btn_left  (btns[2]),
        .btn_right (btns[3]),
        .move_tick (move_tick),
        .open_dirs (open_dirs),
        .dir       (dir),
        .moving    (moving),
        .step      (step),
        .turn_evt  (turn_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic modelReset();
        m_dir    = 2;
        m_moving = 0;
        m_reqv   = 0;
        m_reqd   = 2;
        m_left   = 0;
        m_prev   = 4'b0000;
        e_step   = 0;
        e_turn   = 0;
    endtask

    task automatic modelStep(input bit [3:0] b, input bit tick, input bit [3:0] open);
        bit [3:0] pr;
        int       pd;
        int       cd;
        pr     = b & ~m_prev;
        m_prev = b;
        pd     = -1;
        for (int i = 3; i >= 0; i--) begin
            if (pr[i]) pd = i;
        end
        e_step = 0;
        e_turn = 0;
`ifdef DIR_INSTANT_REVERSE_EN
        if (m_moving && pd >= 0 && pd == opp_tab[m_dir]) begin
            m_dir  = pd;
            e_turn = 1;
            m_reqv = 0;
            pd     = -1;
        end
`endif
        if (tick) begin
            cd = (pd >= 0) ? pd : m_reqd;
            if ((pd >= 0 || m_reqv) && open[cd]) begin
                if (cd != m_dir) e_turn = 1;
                m_dir    = cd;
                m_moving = 1;
                e_step   = 1;
                m_reqv   = 0;
            end else begin
                if (m_moving) begin
                    if (open[m_dir]) e_step = 1;
                    else m_moving = 0;
                end
                if (pd >= 0) begin
                    m_reqv = 1;
                    m_reqd = pd;
                    m_left = HOLD;
                end
                if (m_reqv) begin
                    m_left--;
                    if (m_left == 0) m_reqv = 0;
                end
            end
        end else if (pd >= 0) begin
            m_reqv = 1;
            m_reqd = pd;
            m_left = HOLD;
        end
    endtask

    // Called at a negedge: drive one cycle of inputs, predict, then check after the edge
    task automatic applyStimulus(input logic [3:0] b, input logic tick, input logic [3:0] open);
        btns      = b;
        move_tick = tick;
        open_dirs = open;
        modelStep(b, tick, open);
        @(posedge clk);
        #1;
        checkOutput("dir",      int'(dir),      m_dir);
        checkOutput("moving",   int'(moving),   int'(m_moving));
        checkOutput("step",     int'(step),     int'(e_step));
        checkOutput("turn_evt", int'(turn_evt), int'(e_turn));
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rb;
        logic [3:0] mask;
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        btns      = 4'b0000;
        move_tick = 1'b0;
        open_dirs = 4'b0000;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dir",    int'(dir),      2);
        checkOutput("rst_moving", int'(moving),   0);
        checkOutput("rst_step",   int'(step),     0);
        checkOutput("rst_turn",   int'(turn_evt), 0);
        @(negedge clk);
        rst = 1'b1;

        // Idle tick with no request
        applyStimulus(4'b0000, 1'b1, 4'b0100);
        checkOutput("idle_no_req", int'(moving), 0);

        // Buffered RIGHT taken three cycles later
        applyStimulus(4'b1000, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 4'b1000);
        checkOutput("plan_right_dir",  int'(dir),      3);
        checkOutput("plan_right_turn", int'(turn_evt), 1);
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("plan_turn_once",  int'(turn_evt), 0);

        // UP pending while the corridor continues, then taken at the junction
        applyStimulus(4'b0001, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 4'b1000);
        applyStimulus(4'b0000, 1'b1, 4'b1001);
        checkOutput("plan_up_dir", int'(dir), 0);

        // DOWN request expires after HOLD blocked ticks
        applyStimulus(4'b0010, 1'b0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 4'b0001);
        applyStimulus(4'b0000, 1'b1, 4'b0001);
        applyStimulus(4'b0000, 1'b1, 4'b0011);
        checkOutput("plan_expired", int'(dir), 0);

        // Simultaneous UP+LEFT press on a tick: priority plus bypass
        applyStimulus(4'b0000, 1'b1, 4'b0000);
        applyStimulus(4'b0101, 1'b1, 4'b0101);
        checkOutput("plan_prio_dir", int'(dir), 0);

        // LEFT then wall stop
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        applyStimulus(4'b0100, 1'b1, 4'b0100);
        applyStimulus(4'b0100, 1'b1, 4'b0000);
        checkOutput("plan_wall_stop", int'(moving), 0);

        // Random phase
        rb = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            mask = 4'b0000;
            for (int k = 0; k < 4; k++) mask[k] = ($urandom_range(0, 3) == 0);
            rb = rb ^ mask;
            applyStimulus(rb, ($urandom_range(0, 2) == 0), 4'($urandom));
            if (n == 300) begin
                // Asynchronous reset mid-run, with UP held through release
                #2;
                rst  = 1'b0;
                btns = 4'b0001;
                #1;
                checkOutput("async_dir",    int'(dir),      2);
                checkOutput("async_moving", int'(moving),   0);
                checkOutput("async_step",   int'(step),     0);
                checkOutput("async_turn",   int'(turn_evt), 0);
                modelReset();
                @(negedge clk);
                rst = 1'b1;
                applyStimulus(4'b0001, 1'b1, 4'b0001);
                checkOutput("held_press_up", int'(dir), 0);
                rb = 4'b0001;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
